// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Frame layout is {addr, rw, data}, sent MSB first.
package spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // Reads carry an all-zero data field on MOSI
  function automatic logic [FRAME_BITS-1:0] mkFrame(
    input logic [ADDR_W-1:0] a,
    input logic              r,
    input logic [DATA_W-1:0] d
  );
    return {a, r, r ? {DATA_W{1'b0}} : d};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SCLK.
// Counts only while enabled; restarts from zero on every tick.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKDIV - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: 16-bit {addr, rw, data} frame.
// Read data is captured from MISO during the data byte.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);

  state_t state, nextState;

  logic                  tick;
  logic                  active;
  logic                  sclkQ;
  logic                  rwQ;
  logic [4:0]            bitCnt;
  logic [FRAME_BITS-1:0] shReg;
  logic [DATA_W-1:0]     rxReg;
  logic [DATA_W-1:0]     rdataQ;

  assign active = (state == SETUP) ||
                  (state == SHIFT) ||
                  (state == HOLD);

  spi_clk_div #(
    .CLKDIV(CLKDIV)
  ) uDiv (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (active),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (start) nextState = SETUP;
      SETUP: if (tick) nextState = SHIFT;
      SHIFT:
        if (tick && sclkQ &&
            bitCnt == 5'(FRAME_BITS - 1))
          nextState = HOLD;
      HOLD:  if (tick) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Rising half samples MISO, falling half advances MOSI
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shReg  <= '0;
      rxReg  <= '0;
      rdataQ <= '0;
      bitCnt <= '0;
      sclkQ  <= 1'b0;
      rwQ    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE && start): begin
          shReg  <= mkFrame(addr, rw, wdata);
          rwQ    <= rw;
          rxReg  <= '0;
          bitCnt <= '0;
          sclkQ  <= 1'b0;
        end
        (state == SHIFT && tick && !sclkQ): begin
          sclkQ <= 1'b1;
          if (bitCnt >= 5'(DATA_W))
            rxReg <= {rxReg[DATA_W-2:0], MISO};
        end
        (state == SHIFT && tick && sclkQ): begin
          sclkQ  <= 1'b0;
          shReg  <= shReg << 1;
          bitCnt <= bitCnt + 5'd1;
        end
        (state == HOLD && tick && rwQ):
          rdataQ <= rxReg;
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign CS    = !active;
  assign SCLK  = sclkQ;
  assign MOSI  = active & shReg[FRAME_BITS-1];
  assign rdata = rdataQ;

endmodule
